datapath_sched: RTL
===================

DATAPATH_SCHED -- requirements
Module: datapath_sched

Interface
REQ-001 SHALL have parameter OUT_CYCLES, default 1, number of cycles Aout is held high per job (legal range 1-4).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset: synchronous, active-low.
REQ-004 SHALL have port req0  input  1  requester 0 job request, level, held until done0.
REQ-005 SHALL have port req1  input  1  requester 1 job request, level, held until done1.
REQ-006 SHALL have port gnt0  output  1  datapath owned by requester 0.
REQ-007 SHALL have port gnt1  output  1  datapath owned by requester 1.
REQ-008 SHALL have port done0  output  1  one-cycle job-complete pulse to requester 0.
REQ-009 SHALL have port done1  output  1  one-cycle job-complete pulse to requester 1.
REQ-010 SHALL have ports sel1, sel2, sel3, sel4, mux1, mux2  output  1 each  datapath register-load and mux controls.
REQ-011 SHALL have port Aout  output  1  datapath result output enable.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port jobs  output  8  count of completed jobs.

Function
REQ-014 SHALL implement a Moore FSM with states IDLE, LOAD, MUL, ACC, OUT, DONE; all outputs SHALL be decoded from registered state and owner only.
REQ-015 IDLE, no request: SHALL remain in IDLE; all controls 0.
REQ-016 IDLE, at least one request: SHALL go to LOAD on the next edge and latch the owner; gntX SHALL be high from LOAD through DONE inclusive.
REQ-017 Transitions: LOAD->MUL->ACC->OUT, OUT->DONE after OUT_CYCLES cycles in OUT, DONE->IDLE unconditionally.
REQ-018 Decode: LOAD sel1=1, sel3=1; MUL sel2=1, sel4=1; ACC sel2=1, sel4=1, mux1=1, mux2=1; OUT Aout=1; all other controls 0 in each state.
REQ-019 DONE: SHALL pulse doneX for the owner for exactly one cycle, and SHALL increment jobs by 1 with wrap 255->0.
REQ-020 Latency: doneX SHALL assert OUT_CYCLES+3 edges after the edge that samples reqX in IDLE.
REQ-021 SHALL insert exactly one IDLE cycle between consecutive jobs; no back-to-back DONE->LOAD.
REQ-022 A request deasserted mid-job SHALL be ignored; the job SHALL complete and doneX SHALL still pulse.
REQ-023 Requests arriving while busy SHALL be left pending; they are evaluated only in IDLE.
REQ-024 Both requests in IDLE: the winner SHALL be chosen per REQ-029/REQ-030.
REQ-025 gnt0 and gnt1 SHALL never be high simultaneously.

Reset
REQ-026 rst=0 at a clock edge SHALL force IDLE, jobs=0, and last-served pointer=1, regardless of current state, including mid-job.
REQ-027 During and after reset, all outputs SHALL be 0 until a new job is granted; a job aborted by reset SHALL NOT produce doneX.

Configuration
REQ-028 Macro ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-029 With ROUND_ROBIN_EN defined: on contention the requester not last served SHALL win; the pointer SHALL update at LOAD entry.
REQ-030 Without ROUND_ROBIN_EN: req0 SHALL always win on contention, and the pointer logic SHALL be absent.

Verification
REQ-031 rst=0 for 2 cycles, then req0=1 with OUT_CYCLES=1 -> LOAD/MUL/ACC/OUT/DONE controls per REQ-018; done0 pulses 4 edges after sampling; jobs=1.
REQ-032 req0 and req1 held high continuously -> with ROUND_ROBIN_EN grants are 0,1,0,1; without it grants are 0,0,0; one IDLE cycle between each job.
REQ-033 req1 pulsed for 1 cycle only -> job completes; done1 pulses once; jobs increments.
REQ-034 rst=0 asserted during MUL -> next cycle IDLE with all outputs 0 and no done; req0 then completes a job and jobs=1.
REQ-035 OUT_CYCLES=3, 256 jobs -> Aout high for 3 cycles per job; jobs wraps to 0.

Source files
------------

// File: rtl/datapath_sched.sv
// datapath_sched: six-state Moore scheduler granting a shared datapath to one of two requesters.
// Contention policy: define ROUND_ROBIN_EN for round-robin, otherwise req0 has fixed priority.
module datapath_sched #(
    parameter int OUT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       sel1,
    output logic       sel2,
    output logic       sel3,
    output logic       sel4,
    output logic       mux1,
    output logic       mux2,
    output logic       Aout,
    output logic       busy,
    output logic [7:0] jobs
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] MUL  = 3'd2;
    localparam logic [2:0] ACC  = 3'd3;
    localparam logic [2:0] OUT  = 3'd4;
    localparam logic [2:0] DONE = 3'd5;
    localparam logic [1:0] OUT_LAST = 2'(OUT_CYCLES - 1);

    logic [2:0] state_q, state_d;
    logic       owner_q, owner_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] jobs_q, jobs_d;
    logic       pick1;

`ifdef ROUND_ROBIN_EN
    // last_q = 1 means requester 1 was served last, so requester 0 wins the next tie
    logic last_q, last_d;
    always_comb begin
        pick1  = req1 & (~req0 | ~last_q);
        last_d = (state_q == IDLE && (req0 | req1)) ? pick1 : last_q;
    end
    always_ff @(posedge clk) last_q <= !rst ? 1'b1 : last_d;
`else
    always_comb pick1 = req1 & ~req0;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = 2'd0;
        jobs_d  = jobs_q;
        case (state_q)
            IDLE: if (req0 | req1) begin
                state_d = LOAD;
                owner_d = pick1;
            end
            LOAD: state_d = MUL;
            MUL:  state_d = ACC;
            ACC:  state_d = OUT;
            OUT: begin
                cnt_d   = cnt_q + 2'd1;
                state_d = (cnt_q == OUT_LAST) ? DONE : OUT;
            end
            DONE: begin
                state_d = IDLE;
                jobs_d  = jobs_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            cnt_q   <= 2'd0;
            jobs_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            jobs_q  <= jobs_d;
        end
    end

    always_comb begin
        busy  = state_q != IDLE;
        gnt0  = busy & ~owner_q;
        gnt1  = busy & owner_q;
        done0 = (state_q == DONE) & ~owner_q;
        done1 = (state_q == DONE) & owner_q;
        sel1  = state_q == LOAD;
        sel3  = state_q == LOAD;
        sel2  = state_q == MUL || state_q == ACC;
        sel4  = state_q == MUL || state_q == ACC;
        mux1  = state_q == ACC;
        mux2  = state_q == ACC;
        Aout  = state_q == OUT;
        jobs  = jobs_q;
    end
endmodule
